param_counter: RTL and testbench
================================

PARAM_COUNTER -- requirements
Module: param_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, counter width in bits.
REQ-002 The block SHALL have parameter MODULUS, default 16, count range 0..MODULUS-1, legal range 2..2^WIDTH.
REQ-003 The block SHALL have parameter SATURATE, default 0: 0 = wrap at terminal, 1 = hold at terminal.
REQ-004 The block SHALL have port clk, input, 1, single clock; all state changes occur on its rising edge.
REQ-005 The block SHALL have port clr, input, 1, reset, synchronous and active-high.
REQ-006 The block SHALL have port ce, input, 1, count enable.
REQ-007 The block SHALL have port up, input, 1, direction: 1 = increment, 0 = decrement.
REQ-008 The block SHALL have port load, input, 1, parallel load strobe (present only with PCOUNTER_LOAD_EN).
REQ-009 The block SHALL have port din, input, WIDTH, parallel load value (present only with PCOUNTER_LOAD_EN).
REQ-010 The block SHALL have port q, output, WIDTH, registered count value.
REQ-011 The block SHALL have port cout, output, 1, combinational wrap/carry for cascading into the next stage's ce.
REQ-012 The block SHALL have port sat, output, 1, registered flag: count held at terminal (SATURATE=1 only).

Function
REQ-013 Priority per rising edge SHALL be: clr, then load, then ce, then hold.
REQ-014 With ce=1 and up=1, q SHALL become q+1, one-cycle latency.
REQ-015 With ce=1 and up=0, q SHALL become q-1, one-cycle latency.
REQ-016 With ce=0 and no load, q SHALL hold.
REQ-017 In up mode at q=MODULUS-1 with ce=1, q SHALL become 0 (SATURATE=0) or hold (SATURATE=1).
REQ-018 In down mode at q=0 with ce=1, q SHALL become MODULUS-1 (SATURATE=0) or hold (SATURATE=1).
REQ-019 cout SHALL equal ce & ~clr & (up ? q==MODULUS-1 : q==0) when SATURATE=0; cout SHALL be constant 0 when SATURATE=1.
REQ-020 cout SHALL be suppressed (0) during any cycle with load=1.
REQ-021 sat SHALL be set on the edge on which a held terminal count occurs, and cleared on the next edge on which q changes, load, or clr.
REQ-022 A change of up SHALL take effect on the same edge on which it is sampled, with no idle cycle.
REQ-023 Load SHALL take effect regardless of ce; load with din >= MODULUS SHALL clamp q to MODULUS-1.
REQ-024 Arithmetic SHALL be performed at WIDTH bits with wrap handled explicitly; q SHALL never take a value >= MODULUS.
REQ-025 Chained stages (cout to next ce, shared clk/clr) SHALL behave as one counter of radix MODULUS per digit with no extra latency.

Reset
REQ-026 When clr=1 at a rising edge, q SHALL be 0 and sat SHALL be 0 on that edge, overriding load and ce.
REQ-027 clr asserted mid-count SHALL discard the pending increment/decrement/load; counting SHALL resume from 0 on the first edge after clr deasserts.
REQ-028 Out of reset with ce=0, outputs SHALL be q=0, sat=0, cout=0 (cout=0 in down mode also requires ce=0 or clr=1).

Configuration
REQ-029 With macro PCOUNTER_LOAD_EN defined, ports load and din SHALL exist and behave per REQ-013, REQ-020 and REQ-023.
REQ-030 Without PCOUNTER_LOAD_EN, ports load and din SHALL be absent and the load branch SHALL be removed; all other behaviour SHALL be unchanged.
REQ-031 A MODULUS outside 2..2^WIDTH SHALL cause a simulation-time error at elaboration.

Verification
REQ-032 The bench SHALL cover decade counting: WIDTH=4, MODULUS=10, up=1, ce=1 from clr for 12 edges -> q 1..9,0,1,2; cout=1 only while q=9.
REQ-033 The bench SHALL cover down wrap: MODULUS=10, q=0, up=0, ce=1 -> next q=9 and cout=1 in the q=0 cycle.
REQ-034 The bench SHALL cover saturation: SATURATE=1, MODULUS=16, q=15, up=1, ce=1 for 3 edges -> q stays 15, sat=1, cout=0; then up=0 -> q=14 and sat=0.
REQ-035 The bench SHALL cover load (macro on): din=7, load=1, ce=0 -> q=7; din=12 with MODULUS=10 -> q=9; load=1 with clr=1 -> q=0.
REQ-036 The bench SHALL cover cascading: two MODULUS=10 stages chained, ce=1 for 100 edges from clr -> {hi,lo} counts 00..99 then 00, with hi incrementing exactly on the edge on which lo wraps.
REQ-037 The bench SHALL cover reset mid-operation: clr=1 asserted at q=5 with ce=1 -> q=0 on that edge; clr deasserted -> q=1 on the following edge.

Source files
------------

// File: rtl/param_counter.sv
// ---------------------------------------------------------------------------
// param_counter
//
// Modulo-N up/down counter with optional saturation and an optional parallel
// load. It is meant to be cascaded: one stage's cout feeds the next stage's
// ce, and all stages share clk and clr, so a chain behaves as a single
// multi-digit counter with radix MODULUS per digit.
//
// Parameters:
//   WIDTH    - counter width in bits
//   MODULUS  - count range 0..MODULUS-1, legal range 2..2**WIDTH
//   SATURATE - 0: wrap at the terminal count, 1: hold at the terminal count
//
// Ports:
//   clk   in   single clock, all state changes on its rising edge
//   clr   in   synchronous active-high clear (highest priority)
//   ce    in   count enable
//   up    in   direction, 1 = increment, 0 = decrement
//   load  in   parallel load strobe    (only with PCOUNTER_LOAD_EN)
//   din   in   parallel load value     (only with PCOUNTER_LOAD_EN)
//   q     out  registered count value
//   cout  out  combinational wrap/carry, drives the next stage's ce
//   sat   out  registered "held at terminal count" flag (SATURATE=1 only)
//
// Optional feature macro: PCOUNTER_LOAD_EN adds load/din and the load path.
// ---------------------------------------------------------------------------
module param_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ce,
  input  logic             up,
`ifdef PCOUNTER_LOAD_EN
  input  logic             load,
  input  logic [WIDTH-1:0] din,
`endif
  output logic [WIDTH-1:0] q,
  output logic             cout,
  output logic             sat
);

  // Reject an unusable modulus while the design is being elaborated.
  if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
    $error("param_counter: MODULUS=%0d outside legal range 2..%0d",
           MODULUS, 2 ** WIDTH);
  end

  // Terminal count, plus MODULUS one bit wider so that MODULUS = 2**WIDTH
  // still compares correctly against a load value.
  localparam logic [WIDTH-1:0] TOP     = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] q_next;
  logic             sat_next;
  logic             at_top;
  logic             at_bot;
  logic             load_gate;

  assign at_top = (q == TOP);
  assign at_bot = (q == '0);

`ifdef PCOUNTER_LOAD_EN
  assign load_gate = load;
`else
  assign load_gate = 1'b0;
`endif

  // Next-state logic. The count path is worked out first; a load (when the
  // feature is built in) is applied afterwards so it overrides counting.
  // Wrap is explicit at both ends so q never leaves 0..MODULUS-1. The sat
  // flag is set only on an edge where a terminal count is held, and cleared
  // on any edge that moves q or loads.
  always_comb begin
    q_next   = q;
    sat_next = sat;
    if (ce) begin
      if (up) begin
        if (at_top) begin
          if (SATURATE != 0) begin
            sat_next = 1'b1;
          end else begin
            q_next   = '0;
            sat_next = 1'b0;
          end
        end else begin
          q_next   = q + WIDTH'(1);
          sat_next = 1'b0;
        end
      end else begin
        if (at_bot) begin
          if (SATURATE != 0) begin
            sat_next = 1'b1;
          end else begin
            q_next   = TOP;
            sat_next = 1'b0;
          end
        end else begin
          q_next   = q - WIDTH'(1);
          sat_next = 1'b0;
        end
      end
    end
`ifdef PCOUNTER_LOAD_EN
    if (load) begin
      q_next   = ({1'b0, din} >= MOD_EXT) ? TOP : din;
      sat_next = 1'b0;
    end
`endif
  end

  // State register; clr wins over everything, including a pending load.
  always_ff @(posedge clk) begin
    if (clr) begin
      q   <= '0;
      sat <= 1'b0;
    end else begin
      q   <= q_next;
      sat <= sat_next;
    end
  end

  // Carry is asserted in the cycle whose edge will wrap, so a following
  // stage advances on exactly that edge. A saturating counter never wraps,
  // and a load or clear in progress suppresses it.
  assign cout = (SATURATE == 0) ?
                (ce & ~clr & ~load_gate & (up ? at_top : at_bot)) : 1'b0;

endmodule

// File: tb/tb_param_counter.sv
// ---------------------------------------------------------------------------
// tb_param_counter
//
// Scoreboard bench for param_counter. The stimulus process drives inputs
// just after each rising edge and pushes the expected q/cout/sat for that
// cycle into a queue; a monitor pops and compares at the falling edge.
//
// Instances:
//   u_dec  WIDTH=4 MODULUS=10 SATURATE=0 (decade, down wrap, clear, load)
//   u_sat  WIDTH=4 MODULUS=16 SATURATE=1 (saturation)
//   u_lo / u_hi  two MODULUS=10 stages chained through cout -> ce
//
// Load checks are built only when PCOUNTER_LOAD_EN is defined.
// ---------------------------------------------------------------------------
module tb_param_counter;

  logic clk;
  int   cyc;
  int   checks;
  int   errors;

  // decade instance inputs/outputs
  logic       d_clr, d_ce, d_up, d_load;
  logic [3:0] d_din;
  logic [3:0] dec_q;
  logic       dec_cout, dec_sat;

  // saturating instance inputs/outputs
  logic       s_clr, s_ce, s_up;
  logic [3:0] sat_q;
  logic       sat_cout, sat_sat;

  // cascade inputs/outputs
  logic       c_clr, c_ce, c_up;
  logic [3:0] lo_q, hi_q;
  logic       lo_cout, hi_cout, lo_sat, hi_sat;

  typedef struct packed {
    logic [31:0] cyc;
    logic [1:0]  sel;
    logic [3:0]  q;
    logic        cout;
    logic        sat;
  } exp_t;

  exp_t  sb[$];
  string sb_name[$];

  param_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_dec (
    .clk(clk), .clr(d_clr), .ce(d_ce), .up(d_up),
`ifdef PCOUNTER_LOAD_EN
    .load(d_load), .din(d_din),
`endif
    .q(dec_q), .cout(dec_cout), .sat(dec_sat)
  );

  param_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1)) u_sat (
    .clk(clk), .clr(s_clr), .ce(s_ce), .up(s_up),
`ifdef PCOUNTER_LOAD_EN
    .load(1'b0), .din(4'd0),
`endif
    .q(sat_q), .cout(sat_cout), .sat(sat_sat)
  );

  param_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_lo (
    .clk(clk), .clr(c_clr), .ce(c_ce), .up(c_up),
`ifdef PCOUNTER_LOAD_EN
    .load(1'b0), .din(4'd0),
`endif
    .q(lo_q), .cout(lo_cout), .sat(lo_sat)
  );

  param_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_hi (
    .clk(clk), .clr(c_clr), .ce(lo_cout), .up(c_up),
`ifdef PCOUNTER_LOAD_EN
    .load(1'b0), .din(4'd0),
`endif
    .q(hi_q), .cout(hi_cout), .sat(hi_sat)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle tag shared by stimulus (push) and monitor (pop).
  always @(posedge clk) cyc <= cyc + 1;

  // Wait for the next edge, then drive one instance's inputs.
  task automatic applyStimulus(input int sel, input logic c, input logic e,
                               input logic u, input logic l,
                               input logic [3:0] d);
    @(posedge clk);
    #1;
    case (sel)
      0: begin d_clr = c; d_ce = e; d_up = u; d_load = l; d_din = d; end
      1: begin s_clr = c; s_ce = e; s_up = u; end
      default: begin c_clr = c; c_ce = e; c_up = u; end
    endcase
  endtask

  // Record what the selected instance must show in the current cycle.
  task automatic expectOut(input int sel, input logic [3:0] q,
                           input logic co, input logic st, input string nm);
    exp_t e;
    e.cyc  = 32'(cyc);
    e.sel  = 2'(sel);
    e.q    = q;
    e.cout = co;
    e.sat  = st;
    sb.push_back(e);
    sb_name.push_back(nm);
  endtask

  task automatic checkOutput(input exp_t e, input string nm);
    logic [3:0] aq;
    logic       ac;
    logic       as;
    case (e.sel)
      2'd0:    begin aq = dec_q; ac = dec_cout; as = dec_sat; end
      2'd1:    begin aq = sat_q; ac = sat_cout; as = sat_sat; end
      2'd2:    begin aq = lo_q;  ac = lo_cout;  as = lo_sat;  end
      default: begin aq = hi_q;  ac = hi_cout;  as = hi_sat;  end
    endcase
    checks = checks + 3;
    if (aq !== e.q) begin
      errors++;
      $display("[TB] FAIL %s q (cycle %0d): got %0d, expected %0d", nm, e.cyc, aq, e.q);
    end
    if (ac !== e.cout) begin
      errors++;
      $display("[TB] FAIL %s cout (cycle %0d): got %b, expected %b", nm, e.cyc, ac, e.cout);
    end
    if (as !== e.sat) begin
      errors++;
      $display("[TB] FAIL %s sat (cycle %0d): got %b, expected %b", nm, e.cyc, as, e.sat);
    end
  endtask

  // Monitor: compare every entry due in this cycle, mid-cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && int'(sb[0].cyc) <= cyc) begin
      checkOutput(sb.pop_front(), sb_name.pop_front());
    end
  end

  initial begin
    cyc    = 0;
    checks = 0;
    errors = 0;
    d_clr = 1'b1; d_ce = 1'b0; d_up = 1'b1; d_load = 1'b0; d_din = 4'd0;
    s_clr = 1'b1; s_ce = 1'b0; s_up = 1'b1;
    c_clr = 1'b1; c_ce = 1'b0; c_up = 1'b1;
    repeat (2) @(posedge clk);

    // Reset state, down mode with ce=0 must not carry.
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    s_clr = 1'b0;
    c_clr = 1'b0;
    expectOut(0, 4'd0, 1'b0, 1'b0, "dec_reset");
    expectOut(1, 4'd0, 1'b0, 1'b0, "sat_reset");
    expectOut(2, 4'd0, 1'b0, 1'b0, "lo_reset");
    expectOut(3, 4'd0, 1'b0, 1'b0, "hi_reset");

    // Decade count: 1..9,0,1,2 with cout only while q=9.
    applyStimulus(0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    expectOut(0, 4'd0, 1'b0, 1'b0, "dec_start");
    for (int i = 1; i <= 12; i++) begin
      applyStimulus(0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
      expectOut(0, 4'(i % 10), (i % 10) == 9, 1'b0, "dec_count");
    end

    // Clear with ce still high, then down wrap from 0.
    applyStimulus(0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    expectOut(0, 4'd3, 1'b0, 1'b0, "dec_before_clr");
    applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    expectOut(0, 4'd0, 1'b1, 1'b0, "down_wrap_cout");
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    expectOut(0, 4'd9, 1'b0, 1'b0, "down_wrap_q");

    // Direction change takes effect at once; clear at q=5 mid-count.
    applyStimulus(0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    expectOut(0, 4'd9, 1'b1, 1'b0, "up_at_9");
    for (int i = 0; i <= 4; i++) begin
      applyStimulus(0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
      expectOut(0, 4'(i), 1'b0, 1'b0, "count_to_5");
    end
    applyStimulus(0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    expectOut(0, 4'd5, 1'b0, 1'b0, "clr_at_5");
    applyStimulus(0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    expectOut(0, 4'd0, 1'b0, 1'b0, "clr_mid_q0");
    applyStimulus(0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    expectOut(0, 4'd1, 1'b0, 1'b0, "resume_q1");
    applyStimulus(0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    expectOut(0, 4'd1, 1'b0, 1'b0, "hold_ce0");

`ifdef PCOUNTER_LOAD_EN
    // Load with ce=0, clamp, cout suppression, clr over load.
    applyStimulus(0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd7);
    expectOut(0, 4'd1, 1'b0, 1'b0, "pre_load");
    applyStimulus(0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd12);
    expectOut(0, 4'd7, 1'b0, 1'b0, "load_7");
    applyStimulus(0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd3);
    expectOut(0, 4'd9, 1'b0, 1'b0, "load_clamp_cout_off");
    applyStimulus(0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd7);
    expectOut(0, 4'd3, 1'b0, 1'b0, "load_over_ce");
    applyStimulus(0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    expectOut(0, 4'd0, 1'b0, 1'b0, "clr_over_load");
`endif

    // Saturation: climb to 15, hold three edges, then step down.
    applyStimulus(1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    expectOut(1, 4'd0, 1'b0, 1'b0, "sat_start");
    for (int i = 1; i <= 15; i++) begin
      applyStimulus(1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
      expectOut(1, 4'(i), 1'b0, 1'b0, "sat_climb");
    end
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1, 1'b0, 1'b1, (k == 3) ? 1'b0 : 1'b1, 1'b0, 4'd0);
      expectOut(1, 4'd15, 1'b0, 1'b1, "sat_hold");
    end
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    expectOut(1, 4'd14, 1'b0, 1'b0, "sat_release");

    // Two-digit cascade: 00..99 then 00.
    applyStimulus(2, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    expectOut(2, 4'd0, 1'b0, 1'b0, "cas_lo_start");
    expectOut(3, 4'd0, 1'b0, 1'b0, "cas_hi_start");
    for (int i = 1; i <= 100; i++) begin
      applyStimulus(2, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
      expectOut(2, 4'(i % 10), (i % 10) == 9, 1'b0, "cas_lo");
      expectOut(3, 4'((i / 10) % 10), ((i % 10) == 9) && (((i / 10) % 10) == 9),
                1'b0, "cas_hi");
    end
    applyStimulus(2, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);

    // Drain the scoreboard, bounded.
    for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
    end
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
